// File: rtl/cacheline_adaptor_if.sv
// Cache-line side and memory-burst side signals of cacheline_adaptor.
// slave = the adaptor, master = its environment (L2/eviction buffer + memory).
interface cacheline_adaptor_if #(
  parameter int LINE_WIDTH  = 256,
  parameter int BURST_WIDTH = 64
);
  logic [LINE_WIDTH-1:0]  line_i;
  logic [31:0]            address_i;
  logic                   read_i;
  logic                   write_i;
  logic [LINE_WIDTH-1:0]  line_o;
  logic                   resp_o;
  logic [BURST_WIDTH-1:0] burst_i;
  logic [BURST_WIDTH-1:0] burst_o;
  logic [31:0]            address_o;
  logic                   read_o;
  logic                   write_o;
  logic                   resp_i;

  modport slave (
    input  line_i, address_i, read_i, write_i, burst_i, resp_i,
    output line_o, resp_o, burst_o, address_o, read_o, write_o
  );

  modport master (
    output line_i, address_i, read_i, write_i, burst_i, resp_i,
    input  line_o, resp_o, burst_o, address_o, read_o, write_o
  );
endinterface

// File: rtl/cacheline_adaptor.sv
// Splits 256-bit line reads/writes into BEATS-beat memory bursts, one transaction at a time.
// Optional: CACHELINE_ADAPTOR_LINE_ALIGN_EN forces latched address bits [4:0] to zero.
module cacheline_adaptor #(
  parameter int LINE_WIDTH  = 256,
  parameter int BURST_WIDTH = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  cacheline_adaptor_if.slave bus
);
  localparam int BEATS = LINE_WIDTH / BURST_WIDTH;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]                         state;
  logic [CW-1:0]                      cnt;
  logic [BEATS-1:0][BURST_WIDTH-1:0]  wr_line;
  logic [BEATS-1:0][BURST_WIDTH-1:0]  rd_line;
  logic [31:0]                        addr_q;
  logic [31:0]                        addr_in;
  logic                               last_beat;

`ifdef CACHELINE_ADAPTOR_LINE_ALIGN_EN
  assign addr_in = bus.address_i & ~32'h0000_001F;
`else
  assign addr_in = bus.address_i;
`endif

  assign last_beat = bus.resp_i && (cnt == CW'(BEATS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      wr_line <= '0;
      rd_line <= '0;
      addr_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Write wins so evictions drain before the refill that displaced them.
          if (bus.write_i) begin
            wr_line <= bus.line_i;
            addr_q  <= addr_in;
            cnt     <= '0;
            state   <= WRITE;
          end else if (bus.read_i) begin
            addr_q  <= addr_in;
            cnt     <= '0;
            state   <= READ;
          end
        end
        READ: begin
          if (bus.resp_i) begin
            rd_line[cnt] <= bus.burst_i;
            cnt          <= cnt + CW'(1);
            if (last_beat) state <= DONE;
          end
        end
        WRITE: begin
          if (bus.resp_i) begin
            cnt <= cnt + CW'(1);
            if (last_beat) state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.read_o    = (state == READ);
  assign bus.write_o   = (state == WRITE);
  assign bus.resp_o    = (state == DONE);
  assign bus.burst_o   = (state == WRITE) ? wr_line[cnt] : '0;
  assign bus.line_o    = rd_line;
  assign bus.address_o = addr_q;
endmodule
